count_sweep_ctrl: RTL and testbench

//  Controller that drives an N-bit loadable up/down counter through its control pins.
//  It loads a seed value and counts in the start direction until the counter flags terminal count.
//  At each terminal count it reverses direction; it repeats for a programmed number of sweeps.

---
 rtl/count_ctrl_pkg.sv | 14 +
 rtl/count_sweep_ctrl.sv | 114 +++++++++++
 tb/tb_count_sweep_ctrl.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/count_ctrl_pkg.sv
// Shared types and default sizes for the count sweep controller.
package count_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } sweep_state_t;

  localparam int CNT_N_DEF    = 4;
  localparam int SWEEPS_W_DEF = 4;

endpackage

// File: rtl/count_sweep_ctrl.sv
// Count sweep controller: loads a seed into an external up/down counter and
// bounces it between its terminal counts for a requested number of sweeps.
//
// state | meaning
// IDLE  | counter parked, waiting for start
// LOAD  | one cycle, parallel-load the latched seed into the counter
// RUN   | counting; each terminal count bumps the tally and turns around
// DONE  | one-cycle done pulse, then back to IDLE
module count_sweep_ctrl
  import count_ctrl_pkg::*;
#(
  parameter int N        = CNT_N_DEF,
  parameter int SWEEPS_W = SWEEPS_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [N-1:0]        seed,
  input  logic [SWEEPS_W-1:0] sweeps,
  input  logic                start_up,
  output logic                busy,
  output logic                done,
  output logic [SWEEPS_W-1:0] sweep_cnt,
  output logic                cnt_en_b,
  output logic                cnt_load_b,
  output logic                cnt_up,
  output logic [N-1:0]        cnt_load_in,
  input  logic                cnt_rco_b
);

  localparam logic [SWEEPS_W-1:0] SWEEP_ONE = SWEEPS_W'(1);

  sweep_state_t        state_q, state_d;
  logic [N-1:0]        seed_q;
  logic [SWEEPS_W-1:0] sweeps_q;
  logic                dir_q;
  logic [SWEEPS_W-1:0] sweep_inc;
  logic                accept;
  logic                last_sweep;

  assign sweep_inc  = sweep_cnt + SWEEP_ONE;
  assign accept     = (state_q == IDLE) && start;
  assign last_sweep = (sweep_inc == sweeps_q);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; abort overrides every other transition once a run is active
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = (sweeps != '0) ? LOAD : DONE;
      LOAD: state_d = RUN;
      RUN:  if (cnt_rco_b && last_sweep) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && (state_q != IDLE)) state_d = IDLE;
  end

  // Run parameters latch on an accepted start; a zero-sweep request leaves them alone
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seed_q   <= '0;
      sweeps_q <= '0;
    end else if (accept && (sweeps != '0)) begin
      seed_q   <= seed;
      sweeps_q <= sweeps;
    end
  end

  // Direction and tally; the final terminal keeps its direction so cnt_up shows the last sweep
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dir_q     <= 1'b1;
      sweep_cnt <= '0;
    end else if (accept) begin
      sweep_cnt <= '0;
      if (sweeps != '0) dir_q <= start_up;
    end else if ((state_q == RUN) && !abort && cnt_rco_b) begin
      sweep_cnt <= sweep_inc;
      if (!last_sweep) dir_q <= ~dir_q;
    end
  end

  // Counter pins and status; in RUN the terminal flag gates the enable directly so the
  // counter parks on its terminal value for the turn-around edge instead of wrapping
  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    cnt_en_b    = 1'b1;
    cnt_load_b  = 1'b1;
    cnt_up      = dir_q;
    cnt_load_in = seed_q;
    case (state_q)
      LOAD: begin
        busy       = 1'b1;
        cnt_en_b   = 1'b0;
        cnt_load_b = 1'b0;
      end
      RUN: begin
        busy     = 1'b1;
        cnt_en_b = cnt_rco_b;
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_count_sweep_ctrl.sv
// Bench for count_sweep_ctrl paired with a 4-bit loadable up/down counter model.
module tb_count_sweep_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, abort, start_up;
  logic [3:0] seed, sweeps;
  logic       busy, done, cnt_en_b, cnt_load_b, cnt_up, cnt_rco_b;
  logic [3:0] sweep_cnt, cnt_load_in;
  logic [3:0] q = 4'd0;

  int tests = 0;
  int fails = 0;

  count_sweep_ctrl #(.N(4), .SWEEPS_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .seed(seed), .sweeps(sweeps), .start_up(start_up),
    .busy(busy), .done(done), .sweep_cnt(sweep_cnt),
    .cnt_en_b(cnt_en_b), .cnt_load_b(cnt_load_b), .cnt_up(cnt_up),
    .cnt_load_in(cnt_load_in), .cnt_rco_b(cnt_rco_b)
  );

  always #5 clk = ~clk;

  // Counter being driven: terminal flag is high at 15 counting up or 0 counting down
  assign cnt_rco_b = cnt_up ? (q == 4'd15) : (q == 4'd0);

  always @(posedge clk) begin
    if (!cnt_en_b) begin
      if (!cnt_load_b) q <= cnt_load_in;
      else if (cnt_up) q <= q + 4'd1;
      else             q <= q - 4'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One run from an accepted start to done. Expected trajectory comes from the sweep
  // rules: load the seed, walk to the terminal, hold there one edge to turn, repeat.
  task automatic run_sweep(input logic [3:0] s, input logic [3:0] n, input logic up,
                           input bit noise, input bit hold);
    logic [3:0] traj[$];
    logic [3:0] pos;
    logic       d;
    logic       last_dir;
    int         e_exp, e, steps;
    bit         ld_low, en_low;

    pos = s;
    d = up;
    last_dir = up;
    if (n == 0) e_exp = 1;
    else begin
      e_exp = 2;
      traj.push_back(s);
      for (int i = 0; i < int'(n); i++) begin
        steps = d ? (15 - int'(pos)) : int'(pos);
        for (int k = 0; k < steps; k++) begin
          pos = d ? pos + 4'd1 : pos - 4'd1;
          traj.push_back(pos);
        end
        traj.push_back(pos);
        e_exp += steps + 1;
        last_dir = d;
        d = ~d;
      end
    end

    seed = s; sweeps = n; start_up = up; start = 1'b1;
    ld_low = 0; en_low = 0;
    tick();
    e = 1;
    if (!hold) start = 1'b0;
    while (!done && e < 400) begin
      if (!cnt_load_b) ld_low = 1;
      if (!cnt_en_b) en_low = 1;
      if (noise) begin
        seed = 4'($urandom);
        sweeps = 4'($urandom);
        start_up = 1'($urandom);
        if (!hold) start = 1'($urandom);
      end
      tick();
      e++;
      if (e >= 2 && (e - 2) < traj.size()) chk("traj_q", q, traj[e-2]);
    end
    chk("edges_to_done", e, e_exp);
    chk("done_sweep_cnt", sweep_cnt, n);
    chk("done_busy", busy, 0);
    if (n == 0) begin
      chk("zero_load_b_low", ld_low, 0);
      chk("zero_en_b_low", en_low, 0);
    end else begin
      chk("final_q", q, last_dir ? 15 : 0);
      chk("final_dir", cnt_up, last_dir);
    end

    seed = s; sweeps = n; start_up = up;
    if (hold) begin
      tick();
      chk("idle_after_done_busy", busy, 0);
      chk("idle_after_done_pulse", done, 0);
      tick();
      chk("restart_from_idle", busy, 1);
      start = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("restart_abort_busy", busy, 0);
    end else begin
      start = 1'b0;
      tick();
      chk("done_one_cycle", done, 0);
      chk("sweep_cnt_holds", sweep_cnt, n);
    end
  endtask

  task automatic abort_run();
    int w;
    logic [3:0] s;
    s = 4'($urandom_range(0, 8));
    seed = s; sweeps = 4'($urandom_range(1, 15)); start_up = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    w = 0;
    while (!(busy && cnt_load_b && q == 4'd9) && w < 40) begin
      tick();
      w++;
    end
    chk("abort_reach_q9", q, 9);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_sweep_cnt", sweep_cnt, 0);
    chk("abort_en_b", cnt_en_b, 1);
    chk("abort_q", q, 10);
    tick();
    chk("abort_q_frozen", q, 10);
    chk("abort_no_late_done", done, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_sweep_cnt"}, sweep_cnt, 0);
    chk({tag, "_en_b"}, cnt_en_b, 1);
    chk({tag, "_load_b"}, cnt_load_b, 1);
    chk({tag, "_up"}, cnt_up, 1);
    chk({tag, "_load_in"}, cnt_load_in, 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0; abort = 1'b0; seed = 4'd0; sweeps = 4'd0; start_up = 1'b0;
    #3;
    chk_reset_vals("por");
    tick();
    tick();
    reset = 1'b0;
    tick();

    run_sweep(4'd3, 4'd2, 1'b1, 0, 0);
    run_sweep(4'd15, 4'd1, 1'b1, 0, 0);
    run_sweep(4'd0, 4'd1, 1'b0, 0, 0);
    run_sweep(4'd7, 4'd0, 1'b1, 0, 0);
    abort_run();
    run_sweep(4'd5, 4'd3, 1'b0, 1, 1);

    // Reset between edges in the middle of a run
    seed = 4'd2; sweeps = 4'd3; start_up = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat ($urandom_range(3, 20)) tick();
    chk("pre_reset_busy", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_vals("mid_reset");
    tick();
    reset = 1'b0;
    run_sweep(4'd6, 4'd2, 1'b1, 1, 0);

    for (int r = 0; r < 20; r++) begin
      run_sweep(4'($urandom), 4'($urandom_range(0, 6)), 1'($urandom), 1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
